// File: rtl/lap_timer_pkg.sv
// Shared types and helpers for the lap_timer stopwatch block.
package lap_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } lt_state_e;

    // Laps are only captured while the timer is live (running or paused).
    function automatic logic lap_allowed(input lt_state_e s);
        return (s == RUN) || (s == PAUSED);
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Show-ahead synchronous FIFO holding captured lap times.
module lap_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push;
    logic             do_pop;

    assign valid_o = (wr_q != rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign data_o  = valid_o ? mem_q[rd_q[AW-1:0]] : '0;

    // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted then.
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + (AW+1)'(1);
        if (do_pop)  rd_d = rd_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/lap_timer.sv
// Prescaled up/down stopwatch with pause, preload, wrap-or-stop and lap FIFO.
module lap_timer
    import lap_timer_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  logic             wrap_en,
    input  logic             lap,
    input  logic             lap_rd,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             done,
    output logic             tc,
    output logic [WIDTH-1:0] lap_data,
    output logic             lap_valid,
    output logic             lap_full,
    output logic             lap_ovf
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

    lt_state_e        state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             lap_push;
    logic             lap_pop;
    logic             idle_or_paused;

    assign idle_or_paused = (state_q == IDLE) || (state_q == PAUSED);
    assign lap_push       = lap && !clear && lap_allowed(state_q);
    assign lap_pop        = lap_rd && lap_valid;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
        tc_d    = 1'b0;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            count_d = '0;
            presc_d = '0;
            ovf_d   = 1'b0;
        end else begin
            // A load that is ignored (RUN/DONE) does not block pause/start.
            if (load && idle_or_paused) begin
                count_d = load_val;
                presc_d = '0;
            end else if (pause && (state_q == RUN)) begin
                state_d = PAUSED;
            end else if (start && idle_or_paused) begin
                state_d = RUN;
            end else if (state_q == RUN) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (!dir) begin
                        if (count_q == '1) begin
                            tc_d = 1'b1;
                            if (wrap_en) count_d = '0;
                            else         state_d = DONE;
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end else begin
                        if (count_q == '0) begin
                            tc_d = 1'b1;
                            if (wrap_en) count_d = '1;
                            else         state_d = DONE;
                        end else begin
                            count_d = count_q - WIDTH'(1);
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            if (lap_push && lap_full && !lap_pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            presc_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            presc_q <= presc_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    lap_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (lap_push),
        .data_i  (count_q),
        .pop_i   (lap_rd),
        .data_o  (lap_data),
        .valid_o (lap_valid),
        .full_o  (lap_full)
    );

    assign count   = count_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign tc      = tc_q;
    assign lap_ovf = ovf_q;

endmodule

// File: doc/lap_timer.md
# lap_timer

Parametrised stopwatch/timer with up/down counting, prescaled tick, pause/resume, preload, wrap-or-stop terminal behaviour and a lap-capture FIFO. It is the next-generation replacement for the fixed 16-bit free-running stopwatch counter. It sits beside the control logic that consumes elapsed-time values. Lap times are read out later through a show-ahead pop interface.

## Interface
- `WIDTH`, 16: counter width; terminal values 0 and 2^WIDTH-1.
- `PRESCALE`, 1: clock cycles per count step (≥1).
- `LAP_DEPTH`, 4: lap FIFO entries (power of two, ≥2).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: IDLE/PAUSED → RUN.
- `pause` in 1: RUN → PAUSED.
- `clear` in 1: any state → IDLE, count 0.
- `load` in 1: preload count (IDLE/PAUSED only).
- `load_val` in WIDTH: preload value.
- `dir` in 1: 0 up, 1 down; sampled at each step.
- `wrap_en` in 1: 1 wrap at terminal, 0 stop in DONE.
- `lap` in 1: capture current count into FIFO.
- `lap_rd` in 1: pop FIFO head.
- `count` out WIDTH: current count.
- `running` out 1: state==RUN.
- `done` out 1: state==DONE.
- `tc` out 1: one-cycle terminal-count pulse.
- `lap_data` out WIDTH: FIFO head (valid when `lap_valid`).
- `lap_valid` out 1: FIFO non-empty.
- `lap_full` out 1: FIFO full.
- `lap_ovf` out 1: sticky, a lap was dropped.

## Operation
- States: IDLE, RUN, PAUSED, DONE.
  - IDLE: `start` → RUN.
  - RUN: `pause` → PAUSED; saturating terminal step → DONE.
  - PAUSED: `start` → RUN.
  - DONE: only `clear`/`rst` leave it; `start`, `load` ignored.
- Priority per cycle: `rst` > `clear` > `load` > `pause` > `start`.
  - `clear`: state IDLE, count 0, prescaler 0, `lap_ovf` 0. FIFO contents kept.
  - `load` in IDLE/PAUSED: count ← `load_val`, prescaler 0, no state change. Ignored in RUN/DONE.
- Prescaler runs only in RUN. Each RUN cycle: if prescaler==PRESCALE-1, step and set prescaler to 0; else prescaler+1. PAUSED holds the prescaler value; resume continues the partial period.
- Step rules:
  - Up: count+1.
  - Down: count-1.
  - Terminal step (up at 2^WIDTH-1, down at 0) with `wrap_en`=1: count wraps (to 0 up, to 2^WIDTH-1 down), state stays RUN.
  - Terminal step with `wrap_en`=0: count unchanged, state → DONE.
  - Either case: `tc`=1 for exactly one cycle, registered with the new count/state.
- Lap FIFO:
  - `lap` in RUN or PAUSED pushes the `count` value present in that cycle (pre-step). `lap` in IDLE/DONE is ignored.
  - Push when full: value dropped, `lap_ovf` ← 1.
  - `lap_rd` with `lap_valid`=0 is ignored. Simultaneous push and pop when non-empty both occur; occupancy unchanged, no overflow even if full.

## Timing
- Reset values: count 0, state IDLE, prescaler 0, `running` 0, `done` 0, `tc` 0, `lap_valid` 0, `lap_full` 0, `lap_ovf` 0, `lap_data` 0, FIFO empty.
- `start` sampled at edge E: `running`=1 after E. With no prescaler carry, first step is at edge E+PRESCALE; PRESCALE=1 gives count 1 one cycle after `running` rises.
- `pause` at edge E: no step at E, `running`=0 after E.
- `tc` pulse coincides with the count value produced by the terminal step.
- `lap_data`/`lap_valid` update the edge after push into an empty FIFO; `lap_rd` advances the head at that edge.
- `rst` or `clear` mid-RUN takes effect at the same edge, overriding any step or `tc` that cycle.

## Structure
- Package `lap_timer_pkg`: state enum `lt_state_e` (IDLE, RUN, PAUSED, DONE).
- Sub-module `lap_fifo`: parametrised show-ahead synchronous FIFO (WIDTH, LAP_DEPTH) with push/pop/full/valid. The top block owns `lap_ovf`.

## Test plan
- WIDTH=4, PRESCALE=1, up, `wrap_en`=1: `start` → count 1..15, then 0; `tc`=1 exactly on the cycle count shows 0.
- WIDTH=4, down, `wrap_en`=0, `load_val`=3 in IDLE, then `start` → count 2,1,0, then `done`=1, `tc` single pulse, count stays 0; `start` ignored; `clear` → IDLE.
- PRESCALE=3: `start`, `pause` after 4 RUN cycles (count 1, prescaler 1), idle 10 cycles, `start` → next step after exactly 2 RUN cycles.
- LAP_DEPTH=4: 5 `lap` pulses at counts 2,4,6,8,10 → `lap_full`=1, `lap_ovf`=1; pops return 2,4,6,8; `lap_valid` then 0.
- Full FIFO with `lap`+`lap_rd` same cycle → head pops, new value appended, `lap_ovf` unchanged.
- `rst` asserted mid-RUN with `lap` and terminal step in the same cycle → all outputs at reset values next cycle, no `tc`.
